// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand-extension mode encoding used by the load/immediate path.
package cpu_pkg;

   typedef logic [2:0] ext_mode_t;

   localparam ext_mode_t EXT_IMM_ZERO = 3'd0;
   localparam ext_mode_t EXT_IMM_SIGN = 3'd1;
   localparam ext_mode_t EXT_IMM_LUI  = 3'd2;
   localparam ext_mode_t EXT_WORD     = 3'd3;
   localparam ext_mode_t EXT_LB       = 3'd4;
   localparam ext_mode_t EXT_LBU      = 3'd5;
   localparam ext_mode_t EXT_LH       = 3'd6;
   localparam ext_mode_t EXT_LHU      = 3'd7;

endpackage

// File: rtl/ext_unit.sv
// Combinational extender/aligner: immediate extension and little-endian load lane selection,
// with misalignment detection for WORD and halfword accesses.
module ext_unit
   import cpu_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int IMM_W  = 16,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  ext_mode_t         mode,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [IMM_W-1:0] imm_v;

   // Halfword lane ignores off[0]; a set off[0] is reported as misaligned instead.
   assign byte_v = data[{off, 3'b000} +: 8];
   assign half_v = data[{off[OFF_W-1:1], 4'b0000} +: 16];
   assign imm_v  = data[IMM_W-1:0];

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      result = '0;
      err    = 1'b0;
      unique case (mode)
         EXT_IMM_ZERO: result = {{(DATA_W-IMM_W){1'b0}}, imm_v};
         EXT_IMM_SIGN: result = {{(DATA_W-IMM_W){imm_v[IMM_W-1]}}, imm_v};
         EXT_IMM_LUI:  result = {imm_v, {(DATA_W-IMM_W){1'b0}}};
         EXT_WORD: begin
            if (off != '0) err = 1'b1;
            else           result = data;
         end
         EXT_LB:  result = {{(DATA_W-8){byte_v[7]}}, byte_v};
         EXT_LBU: result = {{(DATA_W-8){1'b0}}, byte_v};
         EXT_LH: begin
            if (off[0]) err = 1'b1;
            else        result = {{(DATA_W-16){half_v[15]}}, half_v};
         end
         EXT_LHU: begin
            if (off[0]) err = 1'b1;
            else        result = {{(DATA_W-16){1'b0}}, half_v};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ext_load_stage.sv
// Registered extension stage: ext_unit result captured into a 2-entry valid/ready FIFO
// so W-stage backpressure never reaches M combinationally.
module ext_load_stage
   import cpu_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int IMM_W  = 16,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  ext_mode_t         in_mode,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err
);

   logic [DATA_W-1:0] ext_res;
   logic              ext_err;

   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] data_q [2];
   logic [DATA_W-1:0] data_d [2];
   logic              err_q  [2];
   logic              err_d  [2];
   logic              push, pop;

   ext_unit #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W)
   ) u_ext (
      .mode   (in_mode),
      .off    (in_off),
      .data   (in_data),
      .result (ext_res),
      .err    (ext_err)
   );

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
   // NOTE: blocking updates here let the push see the post-pop count in the same pass.
   always_comb begin
      data_d  = data_q;
      err_d   = err_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
         data_d  = '{default: '0};
         err_d   = '{default: 1'b0};
      end else begin
         if (pop) begin
            data_d[0] = data_q[1];
            err_d[0]  = err_q[1];
            count_d   = count_d - 2'd1;
         end
         if (push) begin
            if (count_d == 2'd0) begin
               data_d[0] = ext_res;
               err_d[0]  = ext_err;
            end else begin
               data_d[1] = ext_res;
               err_d[1]  = ext_err;
            end
            count_d = count_d + 2'd1;
         end
      end
   end

   // NOTE: the two entries are reset too, so outputs are clean 0 straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         count_q <= count_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign out_data = out_valid ? data_q[0] : '0;
   assign out_err  = out_valid ? err_q[0]  : 1'b0;

endmodule

// File: tb/tb_ext_load_stage.sv
// Self-checking bench for ext_load_stage: directed cases plus randomized traffic against a queue model.
module tb_ext_load_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_mode = 3'd0;
   logic [1:0]  in_off = 2'd0;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [32:0] q [$];   // model FIFO: {err, data}

   always #5 clk = ~clk;

   ext_load_stage #(.DATA_W(32), .IMM_W(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_off    (in_off),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference extension computed arithmetically from the mode rules.
   function automatic logic [32:0] ref_ext(input int mode, input int off, input logic [31:0] d);
      int unsigned b, h, imm;
      b   = (d >> (8 * off)) & 32'hFF;
      h   = (d >> (16 * (off / 2))) & 32'hFFFF;
      imm = d & 32'hFFFF;
      case (mode)
         0: return {1'b0, imm};
         1: return {1'b0, (imm >= 32768) ? imm + 32'hFFFF_0000 : imm};
         2: return {1'b0, imm * 65536};
         3: return (off != 0) ? {1'b1, 32'h0} : {1'b0, d};
         4: return {1'b0, (b >= 128) ? b + 32'hFFFF_FF00 : b};
         5: return {1'b0, b};
         6: return (off % 2 != 0) ? {1'b1, 32'h0} : {1'b0, (h >= 32768) ? h + 32'hFFFF_0000 : h};
         default: return (off % 2 != 0) ? {1'b1, 32'h0} : {1'b0, h};
      endcase
   endfunction

   // One clock: compare against the model at negedge, then advance the model at posedge.
   task automatic cycle();
      bit m_push, m_pop;
      @(negedge clk);
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready",  64'(in_ready),  64'(q.size() != 2));
      check("out_data",  64'(out_data),  (q.size() != 0) ? 64'(q[0][31:0]) : 64'd0);
      check("out_err",   64'(out_err),   (q.size() != 0) ? 64'(q[0][32])    : 64'd0);
      m_push = in_valid && (q.size() < 2);
      m_pop  = out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (m_pop)  void'(q.pop_front());
         if (m_push) q.push_back(ref_ext(int'(in_mode), int'(in_off), in_data));
      end
      #1;
   endtask

   // Push one entry with out_ready high and check the head against a hand-derived constant.
   task automatic push_direct(input string tag, input logic [2:0] mode, input logic [1:0] off,
                              input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
      in_valid = 1'b1;
      in_mode  = mode;
      in_off   = off;
      in_data  = d;
      cycle();
      #3;
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"},  64'(out_data),  64'(exp_d));
      check({tag, "_err"},   64'(out_err),   64'(exp_e));
   endtask

   initial begin
      // Reset held, then released away from an edge.
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready),  64'd1);
      check("rst_data",  64'(out_data),  64'd0);
      check("rst_err",   64'(out_err),   64'd0);
      reset_n = 1'b1;
      cycle();

      // Immediate modes back to back.
      out_ready = 1'b1;
      push_direct("imm_zero", 3'd0, 2'd3, 32'h0000_8001, 32'h0000_8001, 1'b0);
      push_direct("imm_sign", 3'd1, 2'd1, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
      push_direct("imm_lui",  3'd2, 2'd2, 32'h0000_8001, 32'h8001_0000, 1'b0);

      // Loads and misalignment.
      push_direct("lb0",   3'd4, 2'd0, 32'h80F1_7F82, 32'hFFFF_FF82, 1'b0);
      push_direct("lbu3",  3'd5, 2'd3, 32'h80F1_7F82, 32'h0000_0080, 1'b0);
      push_direct("lh2",   3'd6, 2'd2, 32'h80F1_7F82, 32'hFFFF_80F1, 1'b0);
      push_direct("lhu0",  3'd7, 2'd0, 32'h80F1_7F82, 32'h0000_7F82, 1'b0);
      push_direct("word0", 3'd3, 2'd0, 32'h80F1_7F82, 32'h80F1_7F82, 1'b0);
      push_direct("lh1",   3'd6, 2'd1, 32'h80F1_7F82, 32'h0000_0000, 1'b1);
      push_direct("word2", 3'd3, 2'd2, 32'h80F1_7F82, 32'h0000_0000, 1'b1);
      push_direct("lb1",   3'd4, 2'd1, 32'h80F1_7F82, 32'h0000_007F, 1'b0);
      in_valid = 1'b0;
      cycle();

      // Backpressure: fill with A, B while stalled.
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 3'd3; in_off = 2'd0; in_data = 32'hAAAA_0001;
      cycle();
      in_data = 32'hBBBB_0002;
      cycle();
      in_valid = 1'b0;
      #3;
      check("bp_full_ready", 64'(in_ready), 64'd0);
      check("bp_head_a",     64'(out_data), 64'hAAAA_0001);
      cycle();
      #3;
      check("bp_stall_a",    64'(out_data), 64'hAAAA_0001);
      out_ready = 1'b1;
      cycle();
      #3;
      check("bp_head_b",     64'(out_data), 64'hBBBB_0002);
      cycle();
      #3;
      check("bp_empty",      64'(out_valid), 64'd0);

      // Simultaneous push and pop at count 1.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hCCCC_0003;
      cycle();
      out_ready = 1'b1; in_data = 32'hDDDD_0004;
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      #3;
      check("pp_head_d",  64'(out_data),  64'hDDDD_0004);
      check("pp_count1",  64'(in_ready),  64'd1);
      check("pp_valid",   64'(out_valid), 64'd1);
      out_ready = 1'b1;
      cycle();

      // Flush at count 2 with a simultaneous push attempt.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1111_0005;
      cycle();
      in_data = 32'h2222_0006;
      cycle();
      flush = 1'b1; in_data = 32'h3333_0007;
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #3;
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_ready", 64'(in_ready),  64'd1);
      cycle();
      cycle();

      // Flush at count 1 with a push: the pushed entry must be discarded.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h4444_0008;
      cycle();
      flush = 1'b1; in_data = 32'h5555_0009;
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      cycle();

      // Asynchronous reset mid-stream with two entries buffered.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h6666_000A;
      cycle();
      in_data = 32'h7777_000B;
      cycle();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("mrst_valid", 64'(out_valid), 64'd0);
      check("mrst_ready", 64'(in_ready),  64'd1);
      check("mrst_data",  64'(out_data),  64'd0);
      q.delete();
      @(negedge clk);
      #2 reset_n = 1'b1;
      cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_mode   = 3'($urandom_range(0, 7));
         in_off    = 2'($urandom_range(0, 3));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 29) == 0);
         cycle();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ext_load_stage.md
Name: ext_load_stage

Overview:
- Registered, parametrised operand-extension stage for the pipelined CPU.
- Extends immediates (zero, sign, LUI) and selects and extends load data (lb/lbu/lh/lhu/lw) from a DM read word using the byte offset.
- Sits between the DM read port and the W-stage register, behind a 2-entry valid/ready buffer so that backpressure from W does not stall M combinationally.
- Flags misaligned accesses.

Parameters:
- DATA_W, 32: datapath width. Must be a multiple of 8 and at least 2*IMM_W.
- IMM_W, 16: immediate field width, taken from the low bits of in_data.
- OFF_W, $clog2(DATA_W/8): byte-offset width. Derived; do not override.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of all buffered entries.
- in_valid, input, 1: input entry present.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_mode, input, 3: extension mode (encoding below).
- in_off, input, OFF_W: byte offset of the access.
- in_data, input, DATA_W: DM read word, or immediate in the low IMM_W bits.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: consumer accepts the head entry.
- out_data, output, DATA_W: extended result.
- out_err, output, 1: misaligned access flag for the head entry.

Behaviour:
- Mode encoding:
  - 0 IMM_ZERO: zero-extend in_data[IMM_W-1:0].
  - 1 IMM_SIGN: sign-extend in_data[IMM_W-1:0].
  - 2 IMM_LUI: in_data[IMM_W-1:0] << (DATA_W-IMM_W), low bits 0.
  - 3 WORD: in_data unchanged.
  - 4 LB: sign-extend byte at lane in_off.
  - 5 LBU: zero-extend byte at lane in_off.
  - 6 LH: sign-extend halfword at lanes {in_off[OFF_W-1:1],0} and +1.
  - 7 LHU: zero-extend the same halfword.
- Lane order is little-endian: byte k = in_data[8k+7:8k].
- Immediate modes ignore in_off and never raise err.
- Misalignment:
  - WORD with in_off != 0: err=1, result 0.
  - LH/LHU with in_off[0]=1: err=1, result 0.
  - LB/LBU are never misaligned.
- The extension result is computed combinationally at input and stored in the buffer. Output comes from registers only.
- Buffer:
  - 2 entries, FIFO order, count in {0,1,2}.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != 2); out_valid = (count != 0).
  - Latency: an entry pushed at edge t is visible on out_* after edge t, i.e. a 1-cycle latency. Full throughput with one push and one pop per cycle.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop at count 1: count stays 1; the new entry becomes head after the edge.
  - push and pop at count 0: impossible, since out_valid=0.
  - push at count 2: blocked, since in_ready=0.
- out_data and out_err are forced to 0 while out_valid=0.
- While out_valid=1 and out_ready=0, out_data and out_err stay stable.
- flush:
  - Highest priority: count becomes 0 at the next edge.
  - A simultaneous push is discarded and a simultaneous pop has no effect.
  - in_ready stays driven by the pre-edge count.
- Reset (reset_n=0, asynchronous):
  - count=0 and both entries cleared to 0.
  - Outputs: out_valid=0, out_data=0, out_err=0, in_ready=1.
  - Reset mid-transfer drops all entries; there is no replay.
  - Deassertion is taken at the next clk edge.

Decomposition:
- Shared package cpu_pkg holds the mode localparams: EXT_IMM_ZERO, EXT_IMM_SIGN, EXT_IMM_LUI, EXT_WORD, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU.
- Sub-module ext_unit: purely combinational extender/aligner taking mode, off and data and producing result and err, parametrised by DATA_W and IMM_W.
- ext_load_stage instantiates ext_unit plus the 2-entry buffer and count logic.

Test Plan:
- Reset: hold reset_n=0, then release -> out_valid=0, out_data=0, out_err=0, in_ready=1. Asserting reset_n=0 mid-stream with count=2 -> out_valid drops immediately.
- Immediate modes: in_data=0x0000_8001 with modes 0/1/2 on back-to-back cycles and out_ready=1 -> outputs 0x0000_8001, 0xFFFF_8001, 0x8001_0000 on consecutive cycles, each 1 cycle after push.
- Loads on in_data=0x80F1_7F82:
  - LB off=0 -> 0xFFFF_FF82.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80F1.
  - LHU off=0 -> 0x0000_7F82.
  - WORD off=0 -> 0x80F1_7F82.
- Misalign: LH off=1 -> err=1, data=0. WORD off=2 -> err=1, data=0. LB off=1 -> err=0.
- Backpressure:
  - out_ready=0, push A, B -> in_ready=0 after the second push, head stays A.
  - Raise out_ready -> A then B in order, no loss or duplication.
  - Simultaneous push and pop at count 1 keeps count 1.
- Flush: count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the pushed entry is never output.
